frame_tx: RTL
=============

# frame_tx

Serializes one vector frame from a point RAM onto a UART line using the frame protocol the FPGA receive side expects: 8 zero sync bytes, then 4 bytes per point MSB first, then the terminator word 0x01010101. It sits between a frame store (a single-port RAM with 1-cycle read latency) and the serial pin. It is used for board-to-board frame forwarding and as the loopback stimulus source for the receive path.

## Interface
- `index_bits`, default 11: width of point indices and counts.
- `max_points`, default 2000: maximum number of points sent per frame; requests above this are clamped.
- `clks_per_bit`, default 217: clk cycles per UART bit (8N1).
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: single-cycle request to send a frame; honoured only when `busy`=0.
- `num_points`, input, `index_bits`: number of points in the frame; sampled on the accepted `start`.
- `read_address`, output, `index_bits`: address of the point being fetched from the frame RAM.
- `point`, input, 25: RAM data, valid 1 cycle after `read_address`. Bit 24 is brightness on/off; bits [23:0] are x/y.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: single-cycle pulse when the last stop bit of the terminator completes.
- `tx`, output, 1: serial line, idle high.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `read_address`=0, state IDLE, all counters 0.
- Latched count: N = min(`num_points`, `max_points`).
- Byte stream on the line: 8×0x00, then for each point i = 0..N-1 the bytes B0 B1 B2 B3, then 0x01 ×4. Total bytes = 12 + 4N.
- Point encoding:
  - B0 = 8'h3F if `point[24]`=1, else 8'h00.
  - B1 = `point[23:16]`, B2 = `point[15:8]`, B3 = `point[7:0]`.
  - B0 is never 0x01, so no point can alias the terminator.
- States:
  - IDLE → SYNC on `start`.
  - SYNC: 8 bytes sent, then → FETCH if N>0, else → TERM.
  - FETCH: drive `read_address`=i for one cycle, capture `point` into a 32-bit shift register on the next cycle, → POINT.
  - POINT: 4 bytes sent. Then i+1<N → FETCH; otherwise → TERM.
  - TERM: 4 bytes sent, → FINISH.
  - FINISH: pulse `done`, → IDLE.
- Byte sequencing uses a 3-bit sync/terminator counter, a 2-bit byte-within-point counter, and an `index_bits` point counter. The point counter never wraps because N ≤ `max_points` < 2^`index_bits`.
- `start` while `busy`=1 is ignored; it is neither queued nor does it alter `num_points` in flight.
- `start` in the same cycle as `done` is ignored. It is accepted from the following cycle on.
- Reset mid-frame aborts immediately: `tx` returns to 1 on the next cycle and the partial frame is dropped. The receiver resynchronizes on the next 8-zero sync.
- `read_address` is changed only in FETCH. It holds its last value otherwise.

## Timing
- Accepted `start` at cycle t: `busy`=1 at t+1, and the first start bit begins no later than t+2.
- Each byte is 10 bits: start bit 0, data LSB first, stop bit 1. Each byte lasts 10·`clks_per_bit` cycles.
- Gap between one stop bit's end and the next start bit: at most 3 cycles including FETCH; at most 1 cycle within SYNC, POINT and TERM.
- `done` is asserted in the cycle after the final stop bit ends. `busy` falls in that same cycle.
- The frame RAM is read only in FETCH, so the writer may update it only while `busy`=0.

## Structure
- Shared package constants:
  - `SYNC_BYTES`=8, `TERM_WORD`=32'h01010101, `BRIGHT_ON`=8'h3F.
  - State encoding for IDLE/SYNC/FETCH/POINT/TERM/FINISH.
  - The receive side uses the same sync and terminator constants.
- One sub-module, `uart_tx`:
  - Ports: `i_Clock`, `i_Reset`, `i_Tx_DV`, `i_Tx_Byte[7:0]`, `o_Tx_Active`, `o_Tx_Serial`, `o_Tx_Done`.
  - Parameter `CLKS_PER_BIT`.
  - `o_Tx_Done` is a 1-cycle pulse at the end of the stop bit.
- `frame_tx` contains only the framing FSM, the counters and the shift register.

## Test plan
- Zero-point frame: N=0, `start` → bytes 00×8, 01×4; `done` one cycle after the last stop bit; `busy` high throughout.
- Single lit point: N=1, RAM[0]=25'h1ABCDEF → 00×8, 3F AB CD EF, 01×4.
- Mixed brightness: N=2, RAM = {25'h0123456, 25'h1FFFFFF} → …, 00 12 34 56, 3F FF FF FF, 01×4. Check `read_address` sequence 0,1 and inter-byte gaps ≤3 cycles.
- Ignored start and clamp:
  - Pulse `start` mid-frame and in the `done` cycle → no second frame.
  - `num_points`=2047 → exactly 2000 points sent (8012 bytes total).
- Reset in the 3rd byte of point 5 → `tx`=1 the next cycle and stays idle. A fresh `start` then sends a complete, correct frame.
- Loopback: drive `tx` into the receive buffer with equal bit timing and N=3. The receiver reports 3 points and its RAM matches the source, with bit 24 preserved.

Source files
------------

// File: rtl/frame_tx_pkg.sv
// Shared framing constants and state encoding for the vector-frame UART link.
// The receive side imports the same sync/terminator constants.
package frame_tx_pkg;

  localparam int          SYNC_BYTES = 8;
  localparam logic [31:0] TERM_WORD  = 32'h01010101;
  localparam logic [7:0]  BRIGHT_ON  = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_FETCH,
    ST_POINT,
    ST_TERM,
    ST_FINISH
  } state_t;

  // Leading byte is 0x00/0x3F, never 0x01, so a point cannot alias the terminator.
  function automatic logic [31:0] encode_point(input logic [24:0] p);
    return {(p[24] ? BRIGHT_ON : 8'h00), p[23:0]};
  endfunction

endpackage

// File: rtl/frame_tx_uart.sv
// 8N1 UART transmitter. One byte per i_Tx_DV while idle; o_Tx_Done pulses
// during the final cycle of the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  uart_state_t   state, state_next;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data;
  logic          bit_end;

  assign bit_end = (clk_cnt == '0);

  always_comb begin
    state_next = state;
    case (state)
      U_IDLE:  if (i_Tx_DV) state_next = U_START;
      U_START: if (bit_end) state_next = U_DATA;
      U_DATA:  if (bit_end && bit_idx == 3'd7) state_next = U_STOP;
      U_STOP:  if (bit_end) state_next = U_IDLE;
      default: state_next = U_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state   <= U_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      data    <= '0;
    end else begin
      state <= state_next;
      if (state == U_IDLE || bit_end) clk_cnt <= BIT_LOAD;
      else                            clk_cnt <= clk_cnt - 1'b1;
      if (state == U_IDLE) begin
        bit_idx <= '0;
        if (i_Tx_DV) data <= i_Tx_Byte;
      end else if (state == U_DATA && bit_end) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    o_Tx_Serial = 1'b1;
    case (state)
      U_START: o_Tx_Serial = 1'b0;
      U_DATA:  o_Tx_Serial = data[bit_idx];
      default: o_Tx_Serial = 1'b1;
    endcase
  end

  assign o_Tx_Active = (state != U_IDLE);
  assign o_Tx_Done   = (state == U_STOP) && bit_end;

endmodule

// File: rtl/frame_tx.sv
// Serializes one vector frame from the point RAM: 8 sync zeros, 4 bytes per point, terminator.
//   state  | meaning
//   IDLE   | waiting for start
//   SYNC   | sending the 8 zero sync bytes
//   FETCH  | address out, then capture RAM data (2 cycles)
//   POINT  | sending the 4 bytes of the current point
//   TERM   | sending the 4 terminator bytes
//   FINISH | done pulse, back to IDLE
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int index_bits   = 11,
  parameter int max_points   = 2000,
  parameter int clks_per_bit = 217
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [index_bits-1:0] num_points,
  output logic [index_bits-1:0] read_address,
  input  logic [24:0]           point,
  output logic                  busy,
  output logic                  done,
  output logic                  tx
);

  localparam logic [index_bits-1:0] MAX_N = index_bits'(max_points);

  state_t                state, state_next;
  logic [2:0]            frame_cnt;
  logic [1:0]            byte_cnt;
  logic [index_bits-1:0] pt_idx;
  logic [index_bits-1:0] n_lat;
  logic [31:0]           shreg;
  logic                  fetch_hold;
  logic                  last_point;
  logic                  tx_dv, tx_active, tx_done;

  assign last_point = (pt_idx + 1'b1) >= n_lat;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_dv      = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SYNC;
      ST_SYNC: begin
        tx_dv = !tx_active;
        if (tx_done && frame_cnt == 3'(SYNC_BYTES - 1))
          state_next = (n_lat != '0) ? ST_FETCH : ST_TERM;
      end
      ST_FETCH:  if (fetch_hold) state_next = ST_POINT;
      ST_POINT: begin
        tx_dv = !tx_active;
        if (tx_done && byte_cnt == 2'd3)
          state_next = last_point ? ST_TERM : ST_FETCH;
      end
      ST_TERM: begin
        tx_dv = !tx_active;
        if (tx_done && frame_cnt == 3'd3) state_next = ST_FINISH;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // The address is loaded on the edge into FETCH so RAM data lands on FETCH's second cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt    <= '0;
      byte_cnt     <= '0;
      pt_idx       <= '0;
      n_lat        <= '0;
      shreg        <= '0;
      fetch_hold   <= 1'b0;
      read_address <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          n_lat     <= (num_points > MAX_N) ? MAX_N : num_points;
          frame_cnt <= '0;
          pt_idx    <= '0;
          shreg     <= '0;
        end
        ST_SYNC: if (tx_done) begin
          frame_cnt <= frame_cnt + 1'b1;
          if (state_next == ST_FETCH) read_address <= '0;
          if (state_next == ST_TERM) begin
            frame_cnt <= '0;
            shreg     <= TERM_WORD;
          end
        end
        ST_FETCH: begin
          fetch_hold <= !fetch_hold;
          if (fetch_hold) begin
            shreg    <= encode_point(point);
            byte_cnt <= '0;
          end
        end
        ST_POINT: if (tx_done) begin
          byte_cnt <= byte_cnt + 1'b1;
          shreg    <= shreg << 8;
          if (state_next == ST_FETCH) begin
            pt_idx       <= pt_idx + 1'b1;
            read_address <= pt_idx + 1'b1;
          end
          if (state_next == ST_TERM) begin
            frame_cnt <= '0;
            shreg     <= TERM_WORD;
          end
        end
        ST_TERM: if (tx_done) begin
          frame_cnt <= frame_cnt + 1'b1;
          shreg     <= shreg << 8;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE) && (state != ST_FINISH);
  assign done = (state == ST_FINISH);

  uart_tx #(.CLKS_PER_BIT(clks_per_bit)) u_uart_tx (
    .i_Clock    (clk),
    .i_Reset    (reset),
    .i_Tx_DV    (tx_dv),
    .i_Tx_Byte  (shreg[31:24]),
    .o_Tx_Active(tx_active),
    .o_Tx_Serial(tx),
    .o_Tx_Done  (tx_done)
  );

endmodule
